// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencing controller for an NTT / INVNTT / MULT / ADDSUB engine.
// Accepts a one-cycle start in IDLE, latches the operation mode, then counts
// cycles in RUN while generating coefficient-RAM read/write enables. It pulses
// done for one cycle and returns to IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request to begin an operation (sampled only in IDLE)
//   mode_in      requested operation: 0=NTT, 1=INVNTT, 2=MULT, 3=ADDSUB
//   mode         latched operation mode for the address generator
//   clk_counter  operation cycle count for the address generator
//   rd_en        coefficient-RAM read enable
//   wr_en        coefficient-RAM write enable
//   busy         high while in RUN
//   done         one-cycle completion pulse
module ntt_ctrl #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode_in,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] clk_counter,
   output logic             rd_en,
   output logic             wr_en,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rl, wl, last;

   // Per-mode read length, write latency and final count (rl + wl - 1).
   always_comb begin
      case (mode_q)
         2'd0, 2'd1: begin
            rl   = CNT_W'(224);
            wl   = CNT_W'(6);
            last = CNT_W'(229);
         end
         2'd2: begin
            rl   = CNT_W'(128);
            wl   = CNT_W'(12);
            last = CNT_W'(139);
         end
         default: begin
            rl   = CNT_W'(64);
            wl   = CNT_W'(4);
            last = CNT_W'(67);
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               mode_d  = mode_in;
               cnt_d   = '0;
            end
         end
         StRun: begin
            // Counter saturates at last; the DONE transition takes over there.
            if (cnt_q == last) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            // start is deliberately not sampled here.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      busy        = (state_q == StRun);
      done        = (state_q == StDone);
      rd_en       = busy && (cnt_q < rl);
      wr_en       = busy && (cnt_q >= wl) && (cnt_q <= last);
      mode        = mode_q;
      clk_counter = cnt_q;
   end

endmodule
